cache_plru_update: RTL

//  Tree pseudo-LRU replacement stage, directly downstream of the read-hit way scanner.

---
 rtl/cache_pkg.sv | 19 +
 rtl/plru_tree_logic.sv | 65 ++++++
 rtl/cache_plru_update.sv | 104 ++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache types and sizing for the read-hit, write-hit, linefill and PLRU blocks.
// Optional build macro PLRU_INVALID_FIRST_EN is consumed by the PLRU modules, not here.
package cache_pkg;

  localparam int PLRU_WAYS_REP = 3;
  localparam int PLRU_INDEX    = 3;
  localparam int NUM_WAYS      = 2**PLRU_WAYS_REP;
  localparam int NUM_SETS      = 2**PLRU_INDEX;

  typedef logic [PLRU_WAYS_REP-1:0] way_t;
  typedef logic [PLRU_INDEX-1:0]    set_t;
  typedef logic [NUM_WAYS-2:0]      plru_tree_t;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } plru_state_e;

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational tree-PLRU evaluation: victim selection and path touch for one set.
// Build macro PLRU_INVALID_FIRST_EN adds vld_mask; a miss then prefers the lowest invalid way.
module plru_tree_logic #(
  parameter int WAYS_REP = 3
) (
  input  logic [2**WAYS_REP-2:0] tree,
  input  logic [WAYS_REP-1:0]    way,
  input  logic                   hit,
`ifdef PLRU_INVALID_FIRST_EN
  input  logic [2**WAYS_REP-1:0] vld_mask,
`endif
  output logic [WAYS_REP-1:0]    sel_way,
  output logic [2**WAYS_REP-2:0] next_tree
);

  localparam int N_WAYS = 2**WAYS_REP;

  logic [WAYS_REP-1:0] walk_way;
  logic [WAYS_REP-1:0] victim;

  // Heap walk: node n lives at bit n-1, a set bit steers to the right child.
  always_comb begin : victim_walk
    int node;
    node = 1;
    for (int l = 0; l < WAYS_REP; l++) begin
      node = tree[node-1] ? (2*node + 1) : (2*node);
    end
    walk_way = WAYS_REP'(node - N_WAYS);
  end

`ifdef PLRU_INVALID_FIRST_EN
  logic                inv_any;
  logic [WAYS_REP-1:0] inv_way;

  // Scan downwards so the lowest-index invalid way is the one left standing.
  always_comb begin
    inv_any = 1'b0;
    inv_way = '0;
    for (int i = N_WAYS-1; i >= 0; i--) begin
      if (!vld_mask[i]) begin
        inv_any = 1'b1;
        inv_way = WAYS_REP'(i);
      end
    end
  end

  assign victim = inv_any ? inv_way : walk_way;
`else
  assign victim = walk_way;
`endif

  assign sel_way = hit ? way : victim;

  // Point every node on the touched path away from it (left branch -> 1).
  always_comb begin : touch_path
    int node;
    next_tree = tree;
    node      = 1;
    for (int l = WAYS_REP-1; l >= 0; l--) begin
      next_tree[node-1] = ~sel_way[l];
      node = 2*node + (sel_way[l] ? 1 : 0);
    end
  end

endmodule

// File: rtl/cache_plru_update.sv
// Tree pseudo-LRU update stage: per-set PLRU trees, INIT sweep, 1-cycle victim/echo response.
// Build macro PLRU_INVALID_FIRST_EN adds req_vld_mask for invalid-way-first victim selection.
module cache_plru_update
  import cache_pkg::*;
#(
  parameter int WAYS_REP = PLRU_WAYS_REP,
  parameter int INDEX    = PLRU_INDEX
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   req_valid,
  input  logic                   req_hit,
  input  logic [INDEX-1:0]       req_set,
  input  logic [WAYS_REP-1:0]    req_way,
`ifdef PLRU_INVALID_FIRST_EN
  input  logic [2**WAYS_REP-1:0] req_vld_mask,
`endif
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic                   rsp_hit,
  output logic [WAYS_REP-1:0]    rsp_way
);

  localparam int N_WAYS = 2**WAYS_REP;
  localparam int N_SETS = 2**INDEX;
  localparam int TREE_W = N_WAYS - 1;
  localparam logic [INDEX-1:0] LAST_SET = INDEX'(N_SETS - 1);

  plru_state_e         state;
  logic [INDEX-1:0]    init_cnt;
  logic [TREE_W-1:0]   tree_mem [N_SETS];
  logic [TREE_W-1:0]   cur_tree;
  logic [TREE_W-1:0]   nxt_tree;
  logic [WAYS_REP-1:0] sel_way;
  logic                accept;

  // flush outranks a same-cycle request; req_ready is only high in IDLE.
  assign accept   = req_valid & req_ready & ~flush;
  assign cur_tree = tree_mem[req_set];

  plru_tree_logic #(
    .WAYS_REP (WAYS_REP)
  ) u_tree (
    .tree      (cur_tree),
    .way       (req_way),
    .hit       (req_hit),
`ifdef PLRU_INVALID_FIRST_EN
    .vld_mask  (req_vld_mask),
`endif
    .sel_way   (sel_way),
    .next_tree (nxt_tree)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      init_cnt  <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (flush) begin
        state     <= INIT;
        init_cnt  <= '0;
        req_ready <= 1'b0;
      end else begin
        case (state)
          INIT: begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == LAST_SET) begin
              state     <= IDLE;
              req_ready <= 1'b1;
            end
          end
          IDLE: begin
            if (accept) begin
              rsp_valid <= 1'b1;
              rsp_hit   <= req_hit;
              rsp_way   <= sel_way;
            end
          end
          default: begin
            state     <= INIT;
            init_cnt  <= '0;
            req_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  // Tree storage is cleared by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      tree_mem[init_cnt] <= '0;
    end else if (accept) begin
      tree_mem[req_set] <= nxt_tree;
    end
  end

endmodule
